ex_mem_alu_dmem: RTL and testbench
==================================

// Module: ex_mem_alu_dmem
// PURPOSE
// - Execute/memory datapath slice of the 5-stage MIPS pipeline: ALU control decode, 32-bit ALU, word data memory.
// - EX side: ALU operands arrive already forwarded and immediate-muxed.
// - The 4-bit ALU op is decoded from the 2-bit ALUOp plus funct = immediate[5:0].
// - MEM side: address is the EX/MEM-registered ALU result; read data feeds MEM/WB in the same cycle.
// PARAMETERS
// - DEPTH  64  data memory size in 32-bit words; power of 2, >= 4
// PORTS
// - clk        in   1   rising-edge clock
// - rst_n      in   1   asynchronous, active-low reset
// - alu_op     in   2   ALUOp from main control
// - funct      in   6   instruction[5:0] (low bits of sign-extended immediate)
// - alu_a      in   32  operand A (forwarded rs)
// - alu_b      in   32  operand B (forwarded rt or immediate)
// - alu_ctrl   out  4   decoded ALU operation
// - alu_zero   out  1   1 when alu_result == 0
// - alu_result out  32  ALU result
// - mem_addr   in   32  byte address
// - mem_read   in   1   MemRead
// - mem_write  in   1   MemWrite
// - mem_wdata  in   32  store data (forwarded rt)
// - mem_rdata  out  32  load data
// BEHAVIOUR
// - ALU control (combinational):
//   - alu_op 00 -> 0010 (add: lw/sw)
//   - alu_op 01 -> 0110 (sub: beq/bne)
//   - alu_op 11 -> 0001 (or: immediate logic)
//   - alu_op 10 decodes funct:
//     - 100000 -> 0010 add; 100010 -> 0110 sub; 100100 -> 0000 and
//     - 100101 -> 0001 or; 101010 -> 0111 slt; 100111 -> 1100 nor
//     - any other funct -> 1111
// - ALU (combinational, 32-bit):
//   - 0000 a&b; 0001 a|b; 0010 a+b; 0110 a-b; 1100 ~(a|b)
//   - 0111 slt: signed (a<b) ? 1 : 0
//   - 1111 and every other code -> result 0
//   - add/sub wrap modulo 2^32; no exception, no stall
//   - alu_zero = (alu_result == 0), so an undefined code gives alu_zero = 1
// - Memory storage and indexing:
//   - DEPTH x 32 array, word index = mem_addr[log2(DEPTH)+1:2]
//   - mem_addr[1:0] ignored (no misalignment trap)
//   - upper address bits ignored, so addresses wrap modulo DEPTH*4
// - Memory read (combinational):
//   - mem_rdata = mem_read ? array[index] : 32'h0
// - Memory write (synchronous):
//   - on posedge clk when mem_write=1 and rst_n=1, array[index] <= mem_wdata
// - Read-during-write, same address: mem_rdata shows old data before the edge and new data after it (no bypass).
// - mem_read and mem_write both 1: legal; write happens and read behaves as above.
// - Reset:
//   - rst_n low asynchronously clears every memory word to 0
//   - while rst_n is low, writes are ignored and mem_rdata = 0
//   - ALU outputs remain purely combinational and are unaffected by reset
//   - reset mid-store: the store is lost and the word reads 0
// - Latency: ALU path 0 cycles; load 0 cycles; store visible from the next cycle.
// CONFIGURATION
// - ALU_OVERFLOW_EN defined:
//   - extra output port alu_overflow (1 bit)
//   - high for signed overflow on codes 0010 and 0110 only, else 0
//   - alu_result is still the wrapped value
// - ALU_OVERFLOW_EN undefined: the port does not exist and no overflow logic is built.
// TESTING
// - Reset, then read any word:
//   - rst_n=0 -> mem_rdata=0
//   - release, read addr 0x10 -> 0
// - Decode of alu_op=10:
//   - funct 101010, a=32'hFFFFFFFF (-1), b=1 -> alu_ctrl=0111, result=1, zero=0
//   - funct 100111, a=0, b=0 -> result=32'hFFFFFFFF
// - alu_op=01, a=b=32'h1234 -> alu_ctrl=0110, result=0, zero=1.
//   - a=5, b=7 -> result=32'hFFFFFFFE
// - Store then load:
//   - write 32'hDEADBEEF at addr 0x8; next cycle read 0x8 -> DEADBEEF
//   - read 0x8+4*DEPTH -> DEADBEEF (wrap)
//   - mem_read=0 -> mem_rdata=0
// - Assert rst_n low mid-cycle while mem_write=1 -> word stays 0 and mem_rdata=0.
// - With ALU_OVERFLOW_EN: add 32'h7FFFFFFF+1 -> result 32'h80000000, alu_overflow=1.
//   - funct 111111 -> alu_ctrl=1111, result=0, zero=1

Source files
------------

// File: rtl/ex_mem_alu_dmem.sv
// Execute/memory datapath slice of a 5-stage MIPS pipeline.
//   - ALU control: decodes alu_op (and funct for R-type) into a 4-bit ALU code.
//   - ALU: 32-bit and/or/add/sub/slt/nor; undefined codes give 0.
//   - Data memory: DEPTH x 32 words, combinational read, synchronous write,
//     asynchronously cleared by rst_n.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   alu_op, funct                ALUOp from main control, instruction[5:0]
//   alu_a, alu_b                 forwarded / immediate-muxed operands
//   alu_ctrl, alu_zero, alu_result  decoded op, zero flag, result
//   mem_addr, mem_read, mem_write, mem_wdata  byte address and controls
//   mem_rdata                    load data (0 when not reading or in reset)
//   alu_overflow                 signed overflow on add/sub (ALU_OVERFLOW_EN only)
// Optional feature macro: ALU_OVERFLOW_EN.
module ex_mem_alu_dmem #(
  parameter int unsigned DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  output logic        alu_zero,
  output logic [31:0] alu_result,
  input  logic [31:0] mem_addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_wdata,
`ifdef ALU_OVERFLOW_EN
  output logic        alu_overflow,
`endif
  output logic [31:0] mem_rdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [3:0] CtrlAnd = 4'b0000;
  localparam logic [3:0] CtrlOr  = 4'b0001;
  localparam logic [3:0] CtrlAdd = 4'b0010;
  localparam logic [3:0] CtrlSub = 4'b0110;
  localparam logic [3:0] CtrlSlt = 4'b0111;
  localparam logic [3:0] CtrlNor = 4'b1100;
  localparam logic [3:0] CtrlBad = 4'b1111;

  // ALU control decode
  always_comb begin
    alu_ctrl = CtrlBad;
    unique case (alu_op)
      2'b00: alu_ctrl = CtrlAdd;
      2'b01: alu_ctrl = CtrlSub;
      2'b11: alu_ctrl = CtrlOr;
      2'b10: begin
        case (funct)
          6'b100000: alu_ctrl = CtrlAdd;
          6'b100010: alu_ctrl = CtrlSub;
          6'b100100: alu_ctrl = CtrlAnd;
          6'b100101: alu_ctrl = CtrlOr;
          6'b101010: alu_ctrl = CtrlSlt;
          6'b100111: alu_ctrl = CtrlNor;
          default:   alu_ctrl = CtrlBad;
        endcase
      end
      default: alu_ctrl = CtrlBad;
    endcase
  end

  // ALU
  always_comb begin
    alu_result = 32'h0;
    case (alu_ctrl)
      CtrlAnd: alu_result = alu_a & alu_b;
      CtrlOr:  alu_result = alu_a | alu_b;
      CtrlAdd: alu_result = alu_a + alu_b;
      CtrlSub: alu_result = alu_a - alu_b;
      CtrlSlt: alu_result = {31'h0, $signed(alu_a) < $signed(alu_b)};
      CtrlNor: alu_result = ~(alu_a | alu_b);
      default: alu_result = 32'h0;
    endcase
  end

  assign alu_zero = (alu_result == 32'h0);

`ifdef ALU_OVERFLOW_EN
  // Signed overflow: result sign differs from a when operands (b negated for sub)
  // share a's sign.
  always_comb begin
    alu_overflow = 1'b0;
    if (alu_ctrl == CtrlAdd) begin
      alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
    end else if (alu_ctrl == CtrlSub) begin
      alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
    end
  end
`endif

  // Data memory
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] mem_idx;
  logic          unused_addr_bits;

  assign mem_idx = mem_addr[AW+1:2];
  // Byte offset and high bits are ignored; addresses wrap modulo DEPTH*4.
  assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (mem_write) begin
      mem_q[mem_idx] <= mem_wdata;
    end
  end

  assign mem_rdata = (mem_read && rst_n) ? mem_q[mem_idx] : 32'h0;

endmodule

// File: tb/tb_ex_mem_alu_dmem.sv
module tb_ex_mem_alu_dmem;

  localparam int unsigned DEPTH = 64;

  logic        clk;
  logic        rst_n;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;
  logic [31:0] alu_result;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef ALU_OVERFLOW_EN
  logic        alu_overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ex_mem_alu_dmem #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_op     (alu_op),
    .funct      (funct),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_zero   (alu_zero),
    .alu_result (alu_result),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
`ifdef ALU_OVERFLOW_EN
    .alu_overflow (alu_overflow),
`endif
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic alu_set(input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
    alu_op = op;
    funct  = f;
    alu_a  = a;
    alu_b  = b;
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    alu_op    = 2'b00;
    funct     = 6'h0;
    alu_a     = 32'h0;
    alu_b     = 32'h0;
    mem_addr  = 32'h10;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    mem_wdata = 32'h0;

    // Reset behaviour
    @(negedge clk);
    #1;
    check("rdata_in_reset", mem_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rdata_after_reset_0x10", mem_rdata, 32'h0);

    // ALU control and ALU
    alu_set(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'h1);
    check("slt_ctrl", {28'h0, alu_ctrl}, 32'h7);
    check("slt_result", alu_result, 32'h1);
    check("slt_zero", {31'h0, alu_zero}, 32'h0);
    alu_set(2'b10, 6'b101010, 32'h1, 32'hFFFF_FFFF);
    check("slt_false", alu_result, 32'h0);
    alu_set(2'b10, 6'b100111, 32'h0, 32'h0);
    check("nor_ctrl", {28'h0, alu_ctrl}, 32'hC);
    check("nor_result", alu_result, 32'hFFFF_FFFF);
    alu_set(2'b01, 6'h0, 32'h1234, 32'h1234);
    check("beq_ctrl", {28'h0, alu_ctrl}, 32'h6);
    check("beq_result", alu_result, 32'h0);
    check("beq_zero", {31'h0, alu_zero}, 32'h1);
    alu_set(2'b01, 6'h0, 32'h5, 32'h7);
    check("sub_wrap", alu_result, 32'hFFFF_FFFE);
    alu_set(2'b00, 6'b100010, 32'h3, 32'h4);
    check("lw_add_ctrl", {28'h0, alu_ctrl}, 32'h2);
    check("lw_add_result", alu_result, 32'h7);
    alu_set(2'b10, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FF00);
    check("and_result", alu_result, 32'h00F0_1200);
    alu_set(2'b10, 6'b100101, 32'hF000_0001, 32'h0000_0010);
    check("or_result", alu_result, 32'hF000_0011);
    alu_set(2'b11, 6'b000000, 32'h0000_00A0, 32'h0000_000A);
    check("ori_ctrl", {28'h0, alu_ctrl}, 32'h1);
    check("ori_result", alu_result, 32'h0000_00AA);
    alu_set(2'b10, 6'b100000, 32'hFFFF_FFFF, 32'h2);
    check("add_wrap", alu_result, 32'h1);
    alu_set(2'b10, 6'b111111, 32'h55, 32'hAA);
    check("bad_ctrl", {28'h0, alu_ctrl}, 32'hF);
    check("bad_result", alu_result, 32'h0);
    check("bad_zero", {31'h0, alu_zero}, 32'h1);
`ifdef ALU_OVERFLOW_EN
    alu_set(2'b00, 6'h0, 32'h7FFF_FFFF, 32'h1);
    check("ovf_add_result", alu_result, 32'h8000_0000);
    check("ovf_add_flag", {31'h0, alu_overflow}, 32'h1);
    alu_set(2'b01, 6'h0, 32'h8000_0000, 32'h1);
    check("ovf_sub_flag", {31'h0, alu_overflow}, 32'h1);
    alu_set(2'b10, 6'b100101, 32'h7FFF_FFFF, 32'h1);
    check("ovf_or_flag", {31'h0, alu_overflow}, 32'h0);
`endif

    // Store then load
    @(negedge clk);
    mem_addr  = 32'h8;
    mem_wdata = 32'hDEAD_BEEF;
    mem_write = 1'b1;
    mem_read  = 1'b0;
    @(negedge clk);
    mem_write = 1'b0;
    mem_read  = 1'b1;
    #1;
    check("load_0x8", mem_rdata, 32'hDEAD_BEEF);
    mem_addr = 32'h8 + 4 * DEPTH;
    #1;
    check("load_wrap", mem_rdata, 32'hDEAD_BEEF);
    mem_addr = 32'hB;
    #1;
    check("load_unaligned", mem_rdata, 32'hDEAD_BEEF);
    mem_addr = 32'hC;
    #1;
    check("load_neighbour", mem_rdata, 32'h0);
    mem_addr = 32'h8;
    mem_read = 1'b0;
    #1;
    check("read_disabled", mem_rdata, 32'h0);

    // Read during write, same address: old before edge, new after
    @(negedge clk);
    mem_addr  = 32'h8;
    mem_wdata = 32'h1357_9BDF;
    mem_write = 1'b1;
    mem_read  = 1'b1;
    #1;
    check("rdw_old", mem_rdata, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    check("rdw_new", mem_rdata, 32'h1357_9BDF);

    // Reset asserted mid-cycle during a store
    @(negedge clk);
    mem_addr  = 32'h20;
    mem_wdata = 32'h5555_AAAA;
    mem_write = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("rdata_reset_mid_store", mem_rdata, 32'h0);
    @(negedge clk);
    mem_write = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    check("store_lost_0x20", mem_rdata, 32'h0);
    mem_addr = 32'h8;
    #1;
    check("reset_cleared_0x8", mem_rdata, 32'h0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
